vga_v_sync_gen: RTL and testbench
=================================

// Module: vga_v_sync_gen
// PURPOSE
// - Downstream of the 800-clock horizontal pixel counter. Consumes h_count and the
//   end-of-line pulse trig_v; keeps the vertical line count and produces registered
//   VGA timing: hsync, vsync, video_on, pixel coordinates, and a frame_start strobe.
// - Vertical phase is a 4-state FSM. Outputs drive the pixel generator and the DAC pins.
// PARAMETERS
// - H_ACTIVE 640 : visible pixels per line
// - H_FP     16  : horizontal front porch, in clocks
// - H_SYNC   96  : hsync width, in clocks
// - H_BP     48  : horizontal back porch; H_TOTAL = sum of the four = 800
// - V_ACTIVE 480 : visible lines
// - V_FP     10  : vertical front porch, in lines
// - V_SYNC   2   : vsync width, in lines
// - V_BP     33  : vertical back porch; V_TOTAL = sum of the four = 525, must be <= 1024
// - SYNC_POL 0   : active level of hsync/vsync (0 = active-low)
// PORTS
// - clk          in   1   pixel clock, 25 MHz; all logic on posedge
// - rst          in   1   synchronous, active-high reset
// - h_count      in   10  horizontal position, 0..H_TOTAL-1, advancing every clk
// - trig_v       in   1   one-clk pulse, high while h_count == H_TOTAL-1
// - v_count      out  10  current line number, 0..V_TOTAL-1
// - v_state      out  2   vertical FSM state
// - hsync        out  1   horizontal sync, registered
// - vsync        out  1   vertical sync, registered
// - video_on     out  1   high in the visible region, registered
// - pix_x        out  10  visible column, registered
// - pix_y        out  10  visible row, registered
// - frame_start  out  1   one-clk strobe for pixel (0,0), registered
// - trig_err     out  1   sticky trig_v protocol error (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst=1 on a posedge) sets:
//   - v_count=0, v_state=V_ACT, video_on=0, pix_x=0, pix_y=0, frame_start=0, trig_err=0
//   - hsync and vsync to the inactive level ~SYNC_POL
//   - rst takes priority over trig_v.
// - v_count advance: on a posedge with trig_v=1, v_count <= (v_count==V_TOTAL-1) ? 0 : v_count+1.
// - FSM: encodings V_ACT=0, V_FP=1, V_SYN=2, V_BP=3. Registered; it updates on the same
//   edge as v_count, based on the next v_count value:
//   - V_ACT -> V_FP  when the next value is V_ACTIVE
//   - V_FP  -> V_SYN when the next value is V_ACTIVE+V_FP
//   - V_SYN -> V_BP  when the next value is V_ACTIVE+V_FP+V_SYNC
//   - V_BP  -> V_ACT when the next value is 0
// - Output stage: one register stage, latency 1 clk from the h_count/v_count pair.
//   Each output is computed from the current h_count and the current (pre-update) v_count/v_state:
//   - hsync: asserted (=SYNC_POL) iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC,
//     i.e. 656..751 with default parameters
//   - vsync: asserted iff v_state==V_SYN, i.e. lines 490..491 with default parameters
//   - video_on: h_count < H_ACTIVE && v_state==V_ACT
//   - pix_x / pix_y: h_count / v_count when visible, else 0
//   - frame_start: (h_count==0 && v_count==0), giving exactly one strobe per frame
// - Line coherence: the trig_v edge coincides with h_count wrapping 799->0, so column 0
//   is always paired with the new line number.
// - Out-of-range input: h_count >= H_TOTAL is treated as blanking, with hsync inactive.
// - Reset mid-frame: v_count restarts at 0 immediately. The remainder of the current
//   line is shown as row 0. No resynchronisation of h_count; the upstream counter free-runs.
// - trig_v held high for N clks: v_count advances N times, unless the check is enabled.
// CONFIGURATION
// - Macro VGA_TRIG_CHECK_EN defined:
//   - trig_v is accepted only when h_count==H_TOTAL-1.
//   - A trig_v at any other h_count leaves v_count and v_state unchanged, and sets
//     trig_err=1 on the next edge; trig_err stays set until rst.
// - Macro not defined:
//   - trig_v is accepted unconditionally.
//   - trig_err is tied to 0 and the comparison logic is absent.
// TESTING
// - Bench drives an 800-clk free-running h_count model with trig_v at 799. Default parameters.
// - Frame wrap: rst, then 420000 clks -> v_count steps 0..524 then 0; frame_start pulses
//   once, 1 clk after h_count=0,v_count=0.
// - hsync: within one line, hsync=0 for exactly 96 clks, in the clks following h_count
//   656..751; hsync=1 at all other times.
// - vsync: vsync=0 for exactly 1600 clks per frame (lines 490..491); it falls 1 clk after
//   h_count=0 of line 490.
// - Visible area: video_on=1 for 307200 clks per frame; the last visible sample is
//   pix_x=639, pix_y=479; pix_x=pix_y=0 whenever video_on=0.
// - Reset mid-frame: rst=1 for 3 clks at v_count=300, h_count=200 -> v_count=0, v_state=0,
//   hsync=vsync=1, video_on=0; the next full line is reported as row 1.
// - Protocol check: trig_v pulse at h_count=100, line 50:
//   - with VGA_TRIG_CHECK_EN: v_count stays 50 and trig_err=1 until rst
//   - without the macro: v_count becomes 51 and trig_err=0

Source files
------------

// File: rtl/vga_v_sync_gen.sv
// rtl/vga_v_sync_gen.sv - vertical line counter, 4-state vertical FSM and registered VGA timing outputs
//
// Purpose: sits behind the free-running horizontal pixel counter. Counts lines on the
// end-of-line pulse trig_v and registers hsync/vsync/video_on/pixel coordinates/frame_start
// one clock after the h_count/v_count pair they describe.
//
// Ports:
//   clk          pixel clock, all logic on posedge
//   rst          synchronous active-high reset (wins over trig_v)
//   h_count      horizontal position from the upstream counter, 0..H_TOTAL-1
//   trig_v       end-of-line pulse, high while h_count == H_TOTAL-1
//   v_count      current line number, 0..V_TOTAL-1
//   v_state      vertical phase: 0 active, 1 front porch, 2 sync, 3 back porch
//   hsync/vsync  registered sync outputs, active level SYNC_POL
//   video_on     registered visible-region flag
//   pix_x/pix_y  registered visible column/row, 0 outside the visible region
//   frame_start  registered one-clock strobe for pixel (0,0)
//   trig_err     sticky trig_v protocol error
//
// Optional feature: define VGA_TRIG_CHECK_EN to accept trig_v only at h_count == H_TOTAL-1
// and flag misplaced pulses on trig_err; otherwise trig_v is always accepted and trig_err is 0.

module vga_v_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_count,
    input  logic       trig_v,
    output logic [9:0] v_count,
    output logic [1:0] v_state,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start,
    output logic       trig_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_END   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYN_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYN_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_END       = 10'(H_TOTAL);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYN_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ACT    = 1'(SYNC_POL);

    typedef enum logic [1:0] {
        VS_ACT = 2'd0,
        VS_FP  = 2'd1,
        VS_SYN = 2'd2,
        VS_BP  = 2'd3
    } vstate_t;

    vstate_t    v_state_q, v_state_d;
    logic [9:0] v_count_q, v_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic       frame_start_q, frame_start_d;
    logic       trig_accept;
    logic       visible;
    logic       hs_window;

`ifdef VGA_TRIG_CHECK_EN
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);

    logic trig_err_q, trig_err_d;
    logic trig_at_eol;

    // A pulse anywhere but the last column is ignored for counting and latched as an error.
    assign trig_at_eol = (h_count == H_LAST);
    assign trig_accept = trig_v && trig_at_eol;

    always_comb begin
        trig_err_d = trig_err_q | (trig_v & ~trig_at_eol);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_err_q <= 1'b0;
        end else begin
            trig_err_q <= trig_err_d;
        end
    end

    assign trig_err = trig_err_q;
`else
    assign trig_accept = trig_v;
    assign trig_err    = 1'b0;
`endif

    // Line counter and vertical phase. The phase tracks the value v_count is about to take,
    // so both registers always describe the same line.
    always_comb begin
        v_count_d = v_count_q;
        v_state_d = v_state_q;
        if (trig_accept) begin
            v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
            case (v_state_q)
                VS_ACT:  if (v_count_d == V_FP_START)  v_state_d = VS_FP;
                VS_FP:   if (v_count_d == V_SYN_START) v_state_d = VS_SYN;
                VS_SYN:  if (v_count_d == V_BP_START)  v_state_d = VS_BP;
                VS_BP:   if (v_count_d == 10'd0)       v_state_d = VS_ACT;
                default: v_state_d = VS_ACT;
            endcase
        end
    end

    // Output stage works from the pre-update line, so column 0 of a new line (which arrives
    // together with the trig_v edge) pairs with the new line number one clock later.
    always_comb begin
        // h_count beyond the line length is blanking; the H_END guard keeps hsync inactive there
        hs_window     = (h_count >= H_SYN_START) && (h_count < H_SYN_END) && (h_count < H_END);
        visible       = (h_count < H_ACT_END) && (v_state_q == VS_ACT);
        hsync_d       = hs_window ? SYNC_ACT : ~SYNC_ACT;
        vsync_d       = (v_state_q == VS_SYN) ? SYNC_ACT : ~SYNC_ACT;
        video_on_d    = visible;
        pix_x_d       = visible ? h_count : 10'd0;
        pix_y_d       = visible ? v_count_q : 10'd0;
        frame_start_d = (h_count == 10'd0) && (v_count_q == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_count_q     <= 10'd0;
            v_state_q     <= VS_ACT;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            video_on_q    <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            v_count_q     <= v_count_d;
            v_state_q     <= v_state_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign v_count     = v_count_q;
    assign v_state     = v_state_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_v_sync_gen.sv
// tb/tb_vga_v_sync_gen.sv - scoreboard bench for vga_v_sync_gen
module tb_vga_v_sync_gen;

`ifdef VGA_TRIG_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h_count = 10'd0;
    logic       trig_v = 1'b0;
    logic [9:0] v_count;
    logic [1:0] v_state;
    logic       hsync, vsync, video_on;
    logic [9:0] pix_x, pix_y;
    logic       frame_start, trig_err;

    vga_v_sync_gen dut (
        .clk(clk), .rst(rst), .h_count(h_count), .trig_v(trig_v),
        .v_count(v_count), .v_state(v_state), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .trig_err(trig_err)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [9:0] vc;
        logic [1:0] st;
        logic       hs;
        logic       vs;
        logic       vid;
        logic [9:0] px;
        logic [9:0] py;
        logic       fs;
        logic       err;
        logic [1:0] tag;   // 0 plain, 1 full line (aggregate counts), 2 run frame aggregate checks
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ref_line = 0;
    bit   ref_err = 1'b0;
    int   hs_full = 0, vs_full = 0, vid_full = 0, fs_cnt = 0;
    int   last_px = -1, last_py = -1;

    function automatic logic [1:0] phase_of(input int line);
        if (line < 480) return 2'd0;
        if (line < 490) return 2'd1;
        if (line < 492) return 2'd2;
        return 2'd3;
    endfunction

    // Reference: behaviour of one input cycle in terms of line number and column.
    task automatic drive(input int h, input bit t, input bit r, input int tag);
        exp_t e;
        int   nl;
        @(negedge clk);
        h_count = 10'(h);
        trig_v  = t;
        rst     = r;
        if (r) begin
            e.hs = 1'b1; e.vs = 1'b1; e.vid = 1'b0; e.px = '0; e.py = '0; e.fs = 1'b0;
            nl = 0;
            ref_err = 1'b0;
        end else begin
            e.hs  = !(h >= 656 && h < 752);
            e.vs  = !(ref_line == 490 || ref_line == 491);
            e.vid = (h < 640) && (ref_line < 480);
            e.px  = e.vid ? 10'(h) : 10'd0;
            e.py  = e.vid ? 10'(ref_line) : 10'd0;
            e.fs  = (h == 0) && (ref_line == 0);
            if (t && (!CHECK || h == 799)) nl = (ref_line == 524) ? 0 : ref_line + 1;
            else nl = ref_line;
            if (CHECK && t && h != 799) ref_err = 1'b1;
        end
        e.err = ref_err;
        ref_line = nl;
        e.vc  = 10'(nl);
        e.st  = phase_of(nl);
        e.tag = 2'(tag);
        q.push_back(e);
    endtask

    task automatic do_line(input bit full, input bit proto);
        int pts[11] = '{0, 1, 2, 639, 640, 655, 656, 700, 751, 752, 798};
        if (full) begin
            for (int h = 0; h < 799; h++) drive(h, 1'b0, 1'b0, 1);
            drive(799, 1'b1, 1'b0, 1);
        end else begin
            if (proto) drive(100, 1'b1, 1'b0, 0);
            foreach (pts[i]) drive(pts[i], 1'b0, 1'b0, 0);
            for (int i = 0; i < 3; i++) drive(int'($urandom_range(1, 1023)), 1'b0, 1'b0, 0);
            drive(799, 1'b1, 1'b0, 0);
        end
    endtask

    task automatic agg(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: every clock presents one output sample; pop and compare.
    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g.vc = v_count; g.st = v_state; g.hs = hsync; g.vs = vsync; g.vid = video_on;
                g.px = pix_x; g.py = pix_y; g.fs = frame_start; g.err = trig_err; g.tag = e.tag;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL cycle_check: got vc=%0d st=%0d hs=%b vs=%b vid=%b px=%0d py=%0d fs=%b err=%b, expected vc=%0d st=%0d hs=%b vs=%b vid=%b px=%0d py=%0d fs=%b err=%b",
                             g.vc, g.st, g.hs, g.vs, g.vid, g.px, g.py, g.fs, g.err,
                             e.vc, e.st, e.hs, e.vs, e.vid, e.px, e.py, e.fs, e.err);
                end
                if (e.tag == 2'd2) begin
                    agg("hsync_low_full_lines", hs_full, 4 * 96);
                    agg("vsync_low_per_frame", vs_full, 1600);
                    agg("video_on_full_lines", vid_full, 2 * 640);
                    agg("frame_start_per_frame", fs_cnt, 1);
                    agg("last_visible_x", last_px, 639);
                    agg("last_visible_y", last_py, 479);
                end
                if (e.tag == 2'd1) begin
                    if (hsync === 1'b0) hs_full++;
                    if (vsync === 1'b0) vs_full++;
                    if (video_on === 1'b1) vid_full++;
                end
                if (frame_start === 1'b1) fs_cnt++;
                if (video_on === 1'b1) begin
                    last_px = int'(pix_x);
                    last_py = int'(pix_y);
                end
            end
        end
    end

    initial begin
        bit done_proto = 1'b0;
        // reset over the end of a line, trig_v high on the last reset cycle
        drive(797, 1'b0, 1'b1, 0);
        drive(798, 1'b0, 1'b1, 0);
        drive(799, 1'b1, 1'b1, 0);
        // frame 1: mostly sparse lines, full lines where exact counts are measured
        for (int ln = 0; ln < 525; ln++)
            do_line(ln == 0 || ln == 479 || ln == 490 || ln == 491, 1'b0);
        drive(300, 1'b0, 1'b0, 2);
        // frame 2: misplaced trig_v on line 50, then a reset mid-line on line 300
        while (ref_line != 300) begin
            do_line(1'b0, (ref_line == 50) && !done_proto);
            if (ref_line >= 50) done_proto = 1'b1;
        end
        for (int h = 0; h < 200; h++) drive(h, 1'b0, 1'b0, 0);
        for (int h = 200; h < 203; h++) drive(h, 1'b0, 1'b1, 0);
        for (int h = 203; h < 799; h++) drive(h, 1'b0, 1'b0, 0);
        drive(799, 1'b1, 1'b0, 0);
        do_line(1'b1, 1'b0);
        drive(300, 1'b0, 1'b0, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        agg("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
